// File: rtl/agc_frame_level_if.sv
// Bundles the capture-buffer read port and the AGC result outputs of agc_frame_level.
interface agc_frame_level_if;
  logic        buf_ready;
  logic [5:0]  rd_addr;
  logic [15:0] rd_data;
  logic        complete;
  logic [15:0] peak;
  logic [7:0]  gain;
  logic        gain_valid;

  // Frame-level AGC side: drives the read address and the results.
  modport master (
    input  buf_ready,
    input  rd_data,
    output rd_addr,
    output complete,
    output peak,
    output gain,
    output gain_valid
  );

  // Capture buffer / result consumer side.
  modport slave (
    output buf_ready,
    output rd_data,
    input  rd_addr,
    input  complete,
    input  peak,
    input  gain,
    input  gain_valid
  );
endinterface

// File: rtl/agc_frame_level.sv
// Reads a captured frame out of the ADC buffer, tracks the peak |sample| and
// steps the AGC gain once per frame, then pulses complete so capture re-arms.
//
// state    | meaning
// IDLE     | waiting for buf_ready, rd_addr parked at 0
// READ     | presenting addresses 0..FRAME_LEN-1, one per cycle
// DRAIN    | RD_LAT cycles for the last reads to return
// UPDATE   | latch peak, step gain
// DONE     | complete / gain_valid pulse, new results visible
// WAIT_LOW | hold off until buf_ready is seen low (no stale retrigger)
module agc_frame_level #(
  parameter int unsigned    FRAME_LEN = 52,
  parameter int unsigned    RD_LAT    = 1,
  parameter logic [15:0]    TARGET_HI = 16'd24000,
  parameter logic [15:0]    TARGET_LO = 16'd12000,
  parameter logic [7:0]     GAIN_MIN  = 8'd0,
  parameter logic [7:0]     GAIN_MAX  = 8'd255,
  parameter logic [7:0]     GAIN_INIT = 8'd128,
  parameter logic [7:0]     GAIN_STEP = 8'd4
) (
  input  logic               clk,
  input  logic               rst,
  agc_frame_level_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE, READ, DRAIN, UPDATE, DONE, WAIT_LOW
  } state_t;

  localparam logic [5:0] LAST_ADDR = 6'(FRAME_LEN - 1);
  localparam logic [1:0] DRAIN_END = 2'(RD_LAT - 1);

  state_t            state;
  logic [RD_LAT-1:0] vld;
  logic [15:0]       acc;
  logic [1:0]        drain_cnt;
  logic [15:0]       abs_sample;
  logic [8:0]        gain_up;
  logic [7:0]        gain_up_sat;
  logic [7:0]        gain_dn_sat;

  // Saturating magnitude: -32768 has no positive twin, so it maps to 32767.
  always_comb begin
    abs_sample = bus.rd_data;
    if (bus.rd_data == 16'h8000)
      abs_sample = 16'h7fff;
    else if (bus.rd_data[15])
      abs_sample = ~bus.rd_data + 16'd1;
  end

  // Gain steps evaluated in 9 bits so neither direction can wrap.
  always_comb begin
    gain_up     = {1'b0, bus.gain} + {1'b0, GAIN_STEP};
    gain_up_sat = (gain_up > {1'b0, GAIN_MAX}) ? GAIN_MAX : gain_up[7:0];
    gain_dn_sat = bus.gain - GAIN_STEP;
    if ({1'b0, bus.gain} < ({1'b0, GAIN_MIN} + {1'b0, GAIN_STEP}))
      gain_dn_sat = GAIN_MIN;
  end

  // Sequencer, read-validity delay line, peak accumulator and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      bus.rd_addr    <= 6'd0;
      bus.complete   <= 1'b0;
      bus.gain_valid <= 1'b0;
      bus.peak       <= 16'd0;
      bus.gain       <= GAIN_INIT;
      acc            <= 16'd0;
      vld            <= '0;
      drain_cnt      <= 2'd0;
    end else begin
      bus.complete   <= 1'b0;
      bus.gain_valid <= 1'b0;
      // vld[k] marks that the address presented k+1 cycles ago was a real read.
      vld <= RD_LAT'({vld, (state == READ)});
      if (vld[RD_LAT-1] && (abs_sample > acc))
        acc <= abs_sample;

      case (state)
        IDLE: begin
          bus.rd_addr <= 6'd0;
          if (bus.buf_ready) begin
            acc   <= 16'd0;
            state <= READ;
          end
        end
        READ: begin
          if (bus.rd_addr == LAST_ADDR) begin
            drain_cnt <= 2'd0;
            state     <= DRAIN;
          end else begin
            bus.rd_addr <= bus.rd_addr + 6'd1;
          end
        end
        DRAIN: begin
          if (drain_cnt == DRAIN_END)
            state <= UPDATE;
          else
            drain_cnt <= drain_cnt + 2'd1;
        end
        UPDATE: begin
          bus.peak <= acc;
          if (acc > TARGET_HI)
            bus.gain <= gain_dn_sat;
          else if (acc < TARGET_LO)
            bus.gain <= gain_up_sat;
          bus.complete   <= 1'b1;
          bus.gain_valid <= 1'b1;
          bus.rd_addr    <= 6'd0;
          state          <= DONE;
        end
        DONE: begin
          state <= WAIT_LOW;
        end
        WAIT_LOW: begin
          if (!bus.buf_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_agc_frame_level.sv
// Directed bench for agc_frame_level: three instances cover the default
// configuration, RD_LAT=3 with a low starting gain, and a high starting gain.
module tb_agc_frame_level;
  localparam int FRAME_LEN = 52;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  agc_frame_level_if if_a ();
  agc_frame_level_if if_b ();
  agc_frame_level_if if_c ();

  agc_frame_level #(.RD_LAT(1))                  dut_a (.clk(clk), .rst(rst), .bus(if_a.master));
  agc_frame_level #(.RD_LAT(3), .GAIN_INIT(8'd2))   dut_b (.clk(clk), .rst(rst), .bus(if_b.master));
  agc_frame_level #(.RD_LAT(1), .GAIN_INIT(8'd253)) dut_c (.clk(clk), .rst(rst), .bus(if_c.master));

  logic        br [3];
  logic [15:0] mem [3][64];
  logic [5:0]  ra [3];
  logic        cp [3];
  logic        gv [3];
  logic [15:0] pk [3];
  logic [7:0]  gn [3];
  logic [15:0] d1_b, d2_b;

  assign if_a.buf_ready = br[0];
  assign if_b.buf_ready = br[1];
  assign if_c.buf_ready = br[2];
  assign ra[0] = if_a.rd_addr;  assign ra[1] = if_b.rd_addr;  assign ra[2] = if_c.rd_addr;
  assign cp[0] = if_a.complete; assign cp[1] = if_b.complete; assign cp[2] = if_c.complete;
  assign gv[0] = if_a.gain_valid; assign gv[1] = if_b.gain_valid; assign gv[2] = if_c.gain_valid;
  assign pk[0] = if_a.peak;     assign pk[1] = if_b.peak;     assign pk[2] = if_c.peak;
  assign gn[0] = if_a.gain;     assign gn[1] = if_b.gain;     assign gn[2] = if_c.gain;

  // Buffer models: one-cycle RAM for a/c, three-stage pipeline for b.
  always @(posedge clk) begin
    if_a.rd_data <= mem[0][if_a.rd_addr];
    if_c.rd_data <= mem[2][if_c.rd_addr];
    d1_b         <= mem[1][if_b.rd_addr];
    d2_b         <= d1_b;
    if_b.rd_data <= d2_b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic fill(input int idx, input logic [15:0] val);
    for (int i = 0; i < 64; i++) mem[idx][i] = val;
  endtask

  // Runs one frame on instance idx and checks addresses, pulse timing and results.
  task automatic run_frame(input int idx, input int lat, input logic [15:0] exp_peak,
                           input logic [7:0] exp_gain, input bit drop_early, input int hold);
    int bad_addr;
    int early;
    int cyc;
    int bad_hold;
    bad_addr = 0;
    early    = 0;
    bad_hold = 0;
    @(negedge clk);
    br[idx] = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= FRAME_LEN; k++) begin
      @(negedge clk);
      if (ra[idx] !== 6'(k - 1)) bad_addr++;
      if (cp[idx] !== 1'b0 || gv[idx] !== 1'b0) early++;
      if (drop_early && k == 5) br[idx] = 1'b0;
    end
    cyc = FRAME_LEN;
    while (cp[idx] !== 1'b1 && cyc < FRAME_LEN + 20) begin
      @(negedge clk);
      cyc++;
      if (cyc <= FRAME_LEN + lat && ra[idx] !== 6'(FRAME_LEN - 1)) bad_addr++;
      if (cp[idx] !== 1'b1 && gv[idx] !== 1'b0) early++;
    end
    chk("rd_addr_seq", bad_addr, 0);
    chk("complete_cycle", cyc, FRAME_LEN + lat + 2);
    chk("early_pulse", early, 0);
    chk("gain_valid", {31'd0, gv[idx]}, 1);
    chk("peak", {16'd0, pk[idx]}, {16'd0, exp_peak});
    chk("gain", {24'd0, gn[idx]}, {24'd0, exp_gain});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (cp[idx] !== 1'b0 || gv[idx] !== 1'b0 || ra[idx] !== 6'd0) bad_hold++;
    end
    if (hold > 0) chk("no_retrigger", bad_hold, 0);
    br[idx] = 1'b0;
    @(negedge clk);
    chk("pulse_width", {30'd0, cp[idx], gv[idx]}, 0);
  endtask

  initial begin
    int late;
    for (int i = 0; i < 3; i++) begin
      br[i] = 1'b0;
      fill(i, 16'd0);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_gain_a", {24'd0, gn[0]}, 128);
    chk("rst_gain_b", {24'd0, gn[1]}, 2);
    chk("rst_gain_c", {24'd0, gn[2]}, 253);
    chk("rst_peak", {16'd0, pk[0]}, 0);
    chk("rst_outs", {24'd0, cp[0], gv[0], ra[0]}, 0);
    rst = 1'b0;

    // Nominal: sample value equals its address.
    for (int i = 0; i < 64; i++) mem[0][i] = 16'(i);
    run_frame(0, 1, 16'd51, 8'd132, 1'b0, 0);

    // Reset in the middle of a frame.
    @(negedge clk);
    br[0] = 1'b1;
    repeat (10) @(negedge clk);
    rst   = 1'b1;
    br[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("midrst_gain", {24'd0, gn[0]}, 128);
    chk("midrst_peak", {16'd0, pk[0]}, 0);
    chk("midrst_outs", {24'd0, cp[0], gv[0], ra[0]}, 0);
    late = 0;
    repeat (60) begin
      @(negedge clk);
      if (cp[0] !== 1'b0 || gv[0] !== 1'b0) late++;
    end
    chk("midrst_no_complete", late, 0);

    // Loud frame with the most negative sample; buf_ready drops mid-frame.
    fill(0, 16'd100);
    mem[0][20] = 16'h8000;
    run_frame(0, 1, 16'd32767, 8'd124, 1'b1, 0);

    // Peak exactly at TARGET_HI, then exactly at TARGET_LO (from a negative sample).
    fill(0, 16'd0);
    mem[0][7] = 16'd24000;
    run_frame(0, 1, 16'd24000, 8'd124, 1'b0, 0);
    fill(0, 16'hEC78);            // -5000
    mem[0][30] = 16'hD120;        // -12000
    run_frame(0, 1, 16'd12000, 8'd124, 1'b0, 10);

    // Fresh frame after the handshake hold: quiet, gain rises.
    for (int i = 0; i < 64; i++) mem[0][i] = 16'(i);
    run_frame(0, 1, 16'd51, 8'd128, 1'b0, 0);

    // RD_LAT=3: only the last sample is non-zero; gain 2 clamps to 0.
    fill(1, 16'd0);
    mem[1][51] = 16'd30000;
    run_frame(1, 3, 16'd30000, 8'd0, 1'b0, 0);

    // Upper clamp: 253 -> 255 -> 255.
    fill(2, 16'd0);
    run_frame(2, 1, 16'd0, 8'd255, 1'b0, 0);
    run_frame(2, 1, 16'd0, 8'd255, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/agc_frame_level.md
Name: agc_frame_level

Overview:
- Downstream consumer of the ADC capture buffer; one clock domain.
- After the buffer signals a full frame, it reads the frame out sample by sample and tracks the peak absolute level.
- Once per frame it updates a stepped AGC gain word, then pulses complete so the capture stage re-arms.

Parameters:
- FRAME_LEN, 52: samples per frame; read addresses 0..FRAME_LEN-1; range 1..64.
- RD_LAT, 1: buffer read latency in clk cycles, from rd_addr to rd_data valid; range 1..3.
- TARGET_HI, 16'd24000: peak above this value decrements gain.
- TARGET_LO, 16'd12000: peak below this value increments gain; must be less than TARGET_HI.
- GAIN_MIN, 8'd0: lower gain clamp.
- GAIN_MAX, 8'd255: upper gain clamp.
- GAIN_INIT, 8'd128: gain value after reset.
- GAIN_STEP, 8'd4: gain change per frame.

Ports:
- clk  in  1  system clock; the buffer read clock is tied to this same clock.
- rst  in  1  synchronous, active-high reset.
- buf_ready  in  1  high while the capture buffer holds a complete frame (the buffer's rden).
- rd_addr  out  6  buffer read address.
- rd_data  in  16  buffer read data, signed two's complement.
- complete  out  1  one-cycle pulse: frame consumed, buffer may re-arm.
- peak  out  16  unsigned peak |sample| of the last frame.
- gain  out  8  current AGC gain.
- gain_valid  out  1  one-cycle pulse when peak and gain update.

Behaviour:
- Reset: state=IDLE, rd_addr=0, complete=0, gain_valid=0, peak=0, gain=GAIN_INIT, accumulator=0. Reset mid-frame aborts the frame immediately; gain is not updated.
- Interface decision: one clock; reset is synchronous and active-high (ports clk, rst).
- States: IDLE, READ, DRAIN, UPDATE, DONE, WAIT_LOW.
- IDLE: rd_addr=0. If buf_ready=1 at edge T, clear accumulator and go to READ.
- READ: rd_addr = 0,1,...,FRAME_LEN-1 on cycles T+1..T+FRAME_LEN, one address per cycle. After the last address, go to DRAIN.
- Sampling: a delay line of RD_LAT stages tracks address validity. rd_data is sampled RD_LAT cycles after each address is presented. Exactly FRAME_LEN samples are accumulated, with no extras and no misses.
- DRAIN: lasts RD_LAT cycles; rd_addr holds FRAME_LEN-1. Then go to UPDATE.
- Absolute value: |x| with saturation, so -32768 gives 32767. acc = max(acc, |x|).
- UPDATE (one cycle):
  - Latch peak <= acc.
  - If acc > TARGET_HI: gain <= max(gain-GAIN_STEP, GAIN_MIN), computed without underflow wrap.
  - Else if acc < TARGET_LO: gain <= min(gain+GAIN_STEP, GAIN_MAX), computed in 9 bits so there is no wrap.
  - Else: hold gain. acc equal to TARGET_HI or TARGET_LO holds.
- DONE (one cycle): complete=1, gain_valid=1. New peak and gain are visible in this same cycle. Then go to WAIT_LOW.
- Latency: complete is high on cycle T+FRAME_LEN+RD_LAT+2 (T+55 with defaults).
- WAIT_LOW: return to IDLE only after buf_ready=0 is sampled. This prevents retriggering on a stale buf_ready.
- buf_ready is ignored in READ, DRAIN, UPDATE and DONE. If it drops mid-frame, the frame still completes normally.
- complete and gain_valid are never high outside DONE.

Test Plan:
- Reset: assert rst for 3 cycles while a frame is reading -> state IDLE, gain=128, peak=0, complete=0, rd_addr=0; no complete pulse afterwards.
- Nominal frame with defaults: buf_ready rises at T, RAM model with RD_LAT=1, samples equal to their address (0..51) -> rd_addr sequence 0..51 on T+1..T+52; complete and gain_valid high only at T+55; peak=51; gain 128->132.
- Loud frame: one sample -32768, the rest 100 -> peak=32767, gain 128->124. Repeat with gain=2 -> gain=0, not 254.
- Hold and boundary: peak exactly 24000, then a frame with peak 12000 -> gain unchanged both frames. Quiet frames starting from gain=253 -> 255, then stays 255.
- Latency parameter: RD_LAT=3, last sample value 30000, all others 0 -> peak=30000, complete at T+57, exactly 52 samples captured.
- Handshake: hold buf_ready high for 10 cycles after complete -> no second frame starts; drop buf_ready, raise it again -> a new frame starts 1 cycle after buf_ready is sampled high.
